// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell consumes an operand bit pair
// per cycle, LSB first, with the carry held in a register between cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Single-bit full adder; returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] a_sh_q,     a_sh_d;
  logic [WIDTH-1:0] b_sh_q,     b_sh_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             carry_q,    carry_d;
  logic             c_msb_in_q, c_msb_in_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             c_out_q,    c_out_d;
  logic             ovf_q,      ovf_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  logic             bit_sum_s;
  logic             bit_cout_s;
  logic             load_s;

  assign {bit_cout_s, bit_sum_s} = full_add(a_sh_q[0], b_sh_q[0], carry_q);

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    c_msb_in_d = c_msb_in_q;
    sum_d      = sum_q;
    c_out_d    = c_out_q;
    ovf_d      = ovf_q;
    load_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = {bit_sum_s, acc_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = bit_cout_s;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // MSB cycle: carry_q is the carry into the top bit.
          c_msb_in_d = carry_q;
          sum_d      = {bit_sum_s, acc_q[WIDTH-1:1]};
          c_out_d    = bit_cout_s;
          ovf_d      = carry_q ^ bit_cout_s;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          load_s  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_s) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = c_in;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      cnt_d = cnt_d;
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      c_msb_in_q <= 1'b0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      c_msb_in_q <= c_msb_in_d;
      sum_q      <= sum_d;
      c_out_q    <= c_out_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected results are queued at start and
// checked when done pulses; each scenario task also checks timing inline.
module tb_serial_adder;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out, overflow;
  logic [W-1:0] sum;

  exp_t exp_q[$];
  exp_t last_res = '0;
  int   n_vec = 0;
  int   n_err = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] full;
    exp_t e;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  // Scoreboard: pop and compare whenever done is seen.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy && done) begin
        n_vec++; n_err++;
        $display("FAIL busy_done_overlap busy=%0b done=%0b required not both 1", busy, done);
      end
      if (done) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done sum=%h with empty scoreboard", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, c_out, overflow} !== {e.s, e.co, e.ov}) begin
            n_err++;
            $display("FAIL result sum=%h c_out=%0b ovf=%0b required sum=%h c_out=%0b ovf=%0b",
                     sum, c_out, overflow, e.s, e.co, e.ov);
          end
          last_res = e;
        end
      end
    end
  end

  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    @(negedge clk);
    start = 1'b1; a = x; b = y; c_in = ci;
    exp_q.push_back(model(x, y, ci));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns edges after the accept edge until done is seen, and busy samples.
  task automatic wait_done(output int edges, output int busy_cyc, output bit timeout);
    edges = 0; busy_cyc = busy ? 1 : 0; timeout = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cyc++;
      if (done) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({busy, done, sum, c_out, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_state busy=%0b done=%0b sum=%h c_out=%0b ovf=%0b required all 0",
               busy, done, sum, c_out, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int edges, bcyc; bit to;
    drive_start(x, y, ci);
    wait_done(edges, bcyc, to);
    n_vec++;
    if (to || edges != W) begin
      n_err++;
      $display("FAIL latency edges=%0d timeout=%0b required %0d", edges, to, W);
    end
    n_vec++;
    if (bcyc != W) begin
      n_err++;
      $display("FAIL busy_cycles got=%0d required %0d", bcyc, W);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse_width done=%0b busy=%0b required 0 0", done, busy);
    end
  endtask

  task automatic test_ignored_start();
    int edges; bit seen;
    exp_t prev;
    prev = last_res;
    drive_start(8'h12, 8'h34, 1'b0);
    edges = 0; seen = 1'b0;
    for (int i = 0; i < 4 * W && !seen; i++) begin
      if (i == 2) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
      else begin start = 1'b0; end
      @(posedge clk); #1;
      edges++;
      if (done) begin
        seen = 1'b1;
      end else begin
        n_vec++;
        if ({sum, c_out, overflow} !== {prev.s, prev.co, prev.ov}) begin
          n_err++;
          $display("FAIL hold_during_run sum=%h required %h", sum, prev.s);
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (!seen || edges != W) begin
      n_err++;
      $display("FAIL ignored_start_latency edges=%0d seen=%0b required %0d", edges, seen, W);
    end
    @(negedge clk);
    n_vec++;
    if (sum !== 8'h46) begin
      n_err++;
      $display("FAIL ignored_start_sum sum=%h required 46", sum);
    end
  endtask

  task automatic test_midrun_reset();
    int edges, bcyc; bit to, dseen;
    drive_start(8'h55, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, sum, c_out, overflow} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset busy=%0b done=%0b sum=%h c_out=%0b ovf=%0b required all 0",
               busy, done, sum, c_out, overflow);
    end
    exp_q.delete();
    last_res = '0;
    dseen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) dseen = 1'b1; end
    @(negedge clk); rst_n = 1'b1;
    repeat (W + 2) begin @(posedge clk); #1; if (done) dseen = 1'b1; end
    n_vec++;
    if (dseen) begin
      n_err++;
      $display("FAIL no_done_after_reset done_seen=1 required 0");
    end
    drive_start(8'h01, 8'h02, 1'b0);
    wait_done(edges, bcyc, to);
    n_vec++;
    if (to || edges != W) begin
      n_err++;
      $display("FAIL post_reset_latency edges=%0d timeout=%0b required %0d", edges, to, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int edges, bcyc; bit to;
    drive_start(8'h21, 8'h03, 1'b0);
    wait_done(edges, bcyc, to);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL b2b_first_done timeout edges=%0d", edges);
    end
    // Still in the DONE cycle: the new start is sampled at the next edge.
    drive_start(8'h10, 8'h20, 1'b0);
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_no_gap busy=%0b done=%0b required 1 0", busy, done);
    end
    wait_done(edges, bcyc, to);
    n_vec++;
    if (to || edges + 1 != W + 1) begin
      n_err++;
      $display("FAIL b2b_spacing cycles=%0d timeout=%0b required %0d", edges + 1, to, W + 1);
    end
    @(negedge clk);
    n_vec++;
    if (sum !== 8'h30) begin
      n_err++;
      $display("FAIL b2b_sum sum=%h required 30", sum);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic(8'h3C, 8'h0F, 1'b0);
    test_basic(8'hFF, 8'h01, 1'b0);
    test_basic(8'h7F, 8'h01, 1'b0);
    test_basic(8'h80, 8'h80, 1'b1);
    test_basic(8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      test_basic(W'($urandom), W'($urandom), 1'($urandom));
    end
    test_ignored_start();
    test_midrun_reset();
    test_back_to_back();
    repeat (2) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
